// File: rtl/phy_chk_pkg.sv
// Shared types, constants and the PRBS7 word-prediction helper for the PHY PRBS checker.
package phy_chk_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // x^7 + x^6 + 1  =>  s[n] = s[n-6] ^ s[n-7]
  localparam int PRBS7_ORDER = 7;
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 7;

  // Widest word the prediction helper supports; callers cast the result to their width.
  localparam int PRBS_MAX_W  = 256;
  localparam int CNT_W       = 32;

  // Seed the serial stream with the top 7 bits of the reference word (oldest first)
  // and extend it by w bits; the extension is the next expected word, bit 0 earliest.
  function automatic logic [PRBS_MAX_W-1:0] prbs7_next_word(input logic [PRBS_MAX_W-1:0] ref_word,
                                                            input int w);
    logic [PRBS_MAX_W+PRBS7_ORDER-1:0] s;
    s = '0;
    s[PRBS7_ORDER-1:0] = ref_word[w-PRBS7_ORDER +: PRBS7_ORDER];
    for (int n = PRBS7_ORDER; n < PRBS_MAX_W + PRBS7_ORDER; n++) begin
      if (n < w + PRBS7_ORDER) s[n] = s[n-PRBS7_TAP_A] ^ s[n-PRBS7_TAP_B];
    end
    return s[PRBS_MAX_W+PRBS7_ORDER-1:PRBS7_ORDER];
  endfunction

  // Add without wrapping: the result sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/phy_prbs_checker_if.sv
// Receive-word input and status/counter outputs of the PRBS checker.
interface phy_prbs_checker_if
  import phy_chk_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32
);
  logic [DATA_BUS_WIDTH-1:0] Data_out;
  logic                      enable;
  logic                      clear_cnt;
  logic                      locked;
  logic                      err_word;
  logic [CNT_W-1:0]          err_word_cnt;
  logic [CNT_W-1:0]          err_bit_cnt;
  logic [CNT_W-1:0]          word_cnt;

  modport master (
    output Data_out, enable, clear_cnt,
    input  locked, err_word, err_word_cnt, err_bit_cnt, word_cnt
  );

  modport slave (
    input  Data_out, enable, clear_cnt,
    output locked, err_word, err_word_cnt, err_bit_cnt, word_cnt
  );
endinterface

// File: rtl/phy_prbs_checker_popcount.sv
// Combinational count of set bits in the mismatch vector.
module popcount_w #(
  parameter int W = 32
) (
  input  logic [W-1:0]       vec,
  output logic [$clog2(W):0] count
);
  // Sum every bit of the vector.
  always_comb begin
    // NOTE: give every always_comb output a value before any branch or loop so no latch is inferred.
    count = '0;
    for (int i = 0; i < W; i++) count = count + {{$clog2(W){1'b0}}, vec[i]};
  end
endmodule

// File: rtl/phy_prbs_checker.sv
// Self-synchronising PRBS7 checker: locks onto the received stream without a start
// marker, then counts checked words, errored words and errored bits.
module phy_prbs_checker
  import phy_chk_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int LOCK_CNT       = 4,
  parameter int UNLOCK_CNT     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  phy_prbs_checker_if.slave  bus
);
  localparam int W      = DATA_BUS_WIDTH;
  localparam int PC_W   = $clog2(W) + 1;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W  = $clog2(UNLOCK_CNT + 1);

  chk_state_e         state_q, state_d;
  logic [W-1:0]       ref_q, ref_d;
  logic [W-1:0]       exp_w;
  logic [W-1:0]       mism;
  logic [PC_W-1:0]    mism_bits;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               locked_q;
  logic               err_word_q, err_word_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   err_word_cnt_q, err_word_cnt_d;
  logic [CNT_W-1:0]   err_bit_cnt_q, err_bit_cnt_d;

  assign exp_w = W'(prbs7_next_word(PRBS_MAX_W'(ref_q), W));
  assign mism  = bus.Data_out ^ exp_w;

  popcount_w #(.W(W)) u_popcount (
    .vec   (mism),
    .count (mism_bits)
  );

  // Next-state, reference and counter updates; nothing moves without enable.
  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    good_d         = good_q;
    run_d          = run_q;
    err_word_d     = 1'b0;
    word_cnt_d     = word_cnt_q;
    err_word_cnt_d = err_word_cnt_q;
    err_bit_cnt_d  = err_bit_cnt_q;

    if (bus.enable) begin
      unique case (state_q)
        SEARCH: begin
          // Re-seed from the raw stream; all-zero words never count toward lock.
          ref_d = bus.Data_out;
          if (mism == '0 && bus.Data_out != '0) good_d = good_q + GOOD_W'(1);
          else                                  good_d = '0;
          if (good_d == GOOD_W'(LOCK_CNT)) begin
            state_d = LOCKED;
            good_d  = '0;
            run_d   = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one bad word cannot corrupt the next.
          ref_d      = exp_w;
          word_cnt_d = sat_add(word_cnt_q, CNT_W'(1));
          if (mism != '0) begin
            err_word_d     = 1'b1;
            err_word_cnt_d = sat_add(err_word_cnt_q, CNT_W'(1));
            err_bit_cnt_d  = sat_add(err_bit_cnt_q, CNT_W'(mism_bits));
            run_d          = run_q + RUN_W'(1);
            if (run_d == RUN_W'(UNLOCK_CNT)) begin
              state_d = SEARCH;
              good_d  = '0;
              run_d   = '0;
              ref_d   = bus.Data_out;
            end
          end else begin
            run_d = '0;
          end
        end
      endcase
    end

    if (bus.clear_cnt) begin
      word_cnt_d     = '0;
      err_word_cnt_d = '0;
      err_bit_cnt_d  = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q        <= SEARCH;
      ref_q          <= '0;
      good_q         <= '0;
      run_q          <= '0;
      locked_q       <= 1'b0;
      err_word_q     <= 1'b0;
      word_cnt_q     <= '0;
      err_word_cnt_q <= '0;
      err_bit_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      good_q         <= good_d;
      run_q          <= run_d;
      locked_q       <= (state_d == LOCKED);
      err_word_q     <= err_word_d;
      word_cnt_q     <= word_cnt_d;
      err_word_cnt_q <= err_word_cnt_d;
      err_bit_cnt_q  <= err_bit_cnt_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.err_word     = err_word_q;
  assign bus.word_cnt     = word_cnt_q;
  assign bus.err_word_cnt = err_word_cnt_q;
  assign bus.err_bit_cnt  = err_bit_cnt_q;

endmodule

// File: tb/tb_phy_prbs_checker.sv
// Scoreboard bench for phy_prbs_checker: a reference model pushes the expected
// outputs for every driven cycle and they are compared one edge later.
module tb_phy_prbs_checker;
  localparam int W      = 32;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phy_prbs_checker_if #(.DATA_BUS_WIDTH(W)) bus ();

  phy_prbs_checker #(
    .DATA_BUS_WIDTH (W),
    .LOCK_CNT       (LOCK),
    .UNLOCK_CNT     (UNLOCK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        locked;
    logic        err_word;
    logic [31:0] ewc;
    logic [31:0] ebc;
    logic [31:0] wc;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic         m_locked, m_errw;
  logic [W-1:0] m_ref;
  int           m_good, m_run;
  logic [31:0]  m_ewc, m_ebc, m_wc;

  // Clean-stream generator: 7-bit window of the serial stream, gen_sr[0] oldest.
  logic [6:0]   gen_sr;
  logic [W-1:0] w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  task automatic next_clean(output logic [W-1:0] word);
    logic nb;
    for (int i = 0; i < W; i++) begin
      word[i] = gen_sr[0];
      nb      = gen_sr[0] ^ gen_sr[1];
      gen_sr  = {nb, gen_sr[6:1]};
    end
  endtask

  function automatic logic [W-1:0] predict(input logic [W-1:0] r);
    logic [6:0]   sr;
    logic [W-1:0] p;
    logic         nb;
    sr = r[W-1 -: 7];
    for (int i = 0; i < W; i++) begin
      nb   = sr[0] ^ sr[1];
      p[i] = nb;
      sr   = {nb, sr[6:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic model_cycle(input logic rst, input logic en, input logic clr, input logic [W-1:0] d);
    logic [W-1:0] e;
    logic [W-1:0] x;
    if (!rst) begin
      m_locked = 1'b0; m_errw = 1'b0; m_ref = '0; m_good = 0; m_run = 0;
      m_ewc = '0; m_ebc = '0; m_wc = '0;
      return;
    end
    m_errw = 1'b0;
    if (en) begin
      e = predict(m_ref);
      x = d ^ e;
      if (!m_locked) begin
        m_good = (x == '0 && d != '0) ? m_good + 1 : 0;
        m_ref  = d;
        if (m_good == LOCK) begin
          m_locked = 1'b1; m_good = 0; m_run = 0;
        end
      end else begin
        m_ref = e;
        m_wc  = sat(m_wc, 1);
        if (x != '0) begin
          m_errw = 1'b1;
          m_ewc  = sat(m_ewc, 1);
          m_ebc  = sat(m_ebc, $countones(x));
          m_run++;
          if (m_run == UNLOCK) begin
            m_locked = 1'b0; m_good = 0; m_run = 0; m_ref = d;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    if (clr) begin
      m_ewc = '0; m_ebc = '0; m_wc = '0;
    end
  endtask

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic step(input logic rst, input logic en, input logic clr, input logic [W-1:0] d);
    obs_t o;
    @(negedge clk);
    rst_n         = rst;
    bus.enable    = en;
    bus.clear_cnt = clr;
    bus.Data_out  = d;
    model_cycle(rst, en, clr, d);
    exp_q.push_back({m_locked, m_errw, m_ewc, m_ebc, m_wc});
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check("locked",       64'(bus.locked),       64'(o.locked));
    check("err_word",     64'(bus.err_word),     64'(o.err_word));
    check("err_word_cnt", 64'(bus.err_word_cnt), 64'(o.ewc));
    check("err_bit_cnt",  64'(bus.err_bit_cnt),  64'(o.ebc));
    check("word_cnt",     64'(bus.word_cnt),     64'(o.wc));
  endtask

  task automatic clean_words(input int n);
    for (int k = 0; k < n; k++) begin
      next_clean(w);
      step(1'b1, 1'b1, 1'b0, w);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.clear_cnt = 1'b0;
    bus.Data_out  = '0;
    gen_sr        = 7'h7F;

    // Reset state
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("reset_locked", 64'(bus.locked), 64'd0);
    check("reset_wc",     64'(bus.word_cnt), 64'd0);

    // Clean stream: lock after word 5; words 6..101 are the 96 checked while locked.
    for (int k = 1; k <= 101; k++) begin
      next_clean(w);
      step(1'b1, 1'b1, 1'b0, w);
      if (k == 4)   check("lock_not_yet_w4", 64'(bus.locked), 64'd0);
      if (k == 5)   check("lock_at_w5",      64'(bus.locked), 64'd1);
      if (k == 100) begin
        check("clean_ewc", 64'(bus.err_word_cnt), 64'd0);
        check("clean_ebc", 64'(bus.err_bit_cnt),  64'd0);
      end
      if (k == 101) check("clean_wc", 64'(bus.word_cnt), 64'd96);
    end

    // Two-bit error in one word: no propagation, lock held
    next_clean(w);
    step(1'b1, 1'b1, 1'b0, w ^ 32'h0002_0001);
    check("flip_pulse", 64'(bus.err_word),     64'd1);
    check("flip_ewc",   64'(bus.err_word_cnt), 64'd1);
    check("flip_ebc",   64'(bus.err_bit_cnt),  64'd2);
    clean_words(10);
    check("flip_hold_lock", 64'(bus.locked),       64'd1);
    check("flip_no_prop",   64'(bus.err_word_cnt), 64'd1);

    // Eight garbage words drop lock; top bit always flipped so relock needs a fresh seed
    step(1'b1, 1'b0, 1'b1, '0);
    for (int g = 0; g < UNLOCK; g++) begin
      next_clean(w);
      step(1'b1, 1'b1, 1'b0, w ^ ($urandom | 32'h8000_0001));
      if (g == UNLOCK - 2) check("unlock_not_yet", 64'(bus.locked), 64'd1);
    end
    check("unlock_locked", 64'(bus.locked),       64'd0);
    check("unlock_ewc",    64'(bus.err_word_cnt), 64'd8);
    for (int k = 1; k <= 5; k++) begin
      next_clean(w);
      step(1'b1, 1'b1, 1'b0, w);
      if (k == 4) check("relock_not_yet", 64'(bus.locked), 64'd0);
      if (k == 5) check("relock_at_w5",   64'(bus.locked), 64'd1);
    end

    // Enable gaps of 0-3 idle cycles with junk on the bus
    for (int k = 0; k < 30; k++) begin
      next_clean(w);
      step(1'b1, 1'b1, 1'b0, w);
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, 1'b0, $urandom);
    end
    check("gap_locked", 64'(bus.locked),       64'd1);
    check("gap_ewc",    64'(bus.err_word_cnt), 64'd8);

    // clear_cnt in the same cycle as an error: counters read 0, pulse still seen
    next_clean(w);
    step(1'b1, 1'b1, 1'b1, w ^ 32'h0000_0010);
    check("clr_pulse", 64'(bus.err_word),     64'd1);
    check("clr_ewc",   64'(bus.err_word_cnt), 64'd0);
    check("clr_ebc",   64'(bus.err_bit_cnt),  64'd0);
    check("clr_wc",    64'(bus.word_cnt),     64'd0);

    // Saturation of err_bit_cnt from a preset near the top
    force dut.err_bit_cnt_q = 32'hFFFF_FFF0;
    m_ebc = 32'hFFFF_FFF0;
    step(1'b1, 1'b0, 1'b0, '0);
    release dut.err_bit_cnt_q;
    next_clean(w);
    step(1'b1, 1'b1, 1'b0, w ^ 32'h0000_FFFF);
    clean_words(2);
    next_clean(w);
    step(1'b1, 1'b1, 1'b0, w ^ 32'hFFFF_0000);
    check("sat_ebc", 64'(bus.err_bit_cnt),  64'hFFFF_FFFF);
    check("sat_ewc", 64'(bus.err_word_cnt), 64'd2);

    // Mid-stream reset overrides enable and clear_cnt
    next_clean(w);
    step(1'b0, 1'b1, 1'b1, w);
    check("midrst_locked", 64'(bus.locked),      64'd0);
    check("midrst_ebc",    64'(bus.err_bit_cnt), 64'd0);

    // All-zero stream never locks
    for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 1'b0, '0);
    check("zero_no_lock", 64'(bus.locked), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phy_prbs_checker.md
# phy_prbs_checker

Self-synchronising PRBS7 checker that sits directly downstream of the PHY receive path and consumes its recovered parallel word `Data_out`. The PHY's TX-to-RX latency is unbounded and unknown, so the checker does not align to a start point. It locks onto the incoming PRBS7 stream by itself, then counts word errors and bit errors. It gives bring-up and regression benches a hardware pass/fail indication that is independent of latency.

## Interface
- `DATA_BUS_WIDTH`, default 32: received word width; must be ≥ 8.
- `LOCK_CNT`, default 4: consecutive predicted-correct words needed to declare lock.
- `UNLOCK_CNT`, default 8: consecutive errored words, while locked, that force a return to search.
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, synchronous and active-low.
- `Data_out`  in  `DATA_BUS_WIDTH`: PHY recovered word; bit 0 is the earliest bit on the line.
- `enable`  in  1: `Data_out` is valid this cycle.
- `clear_cnt`  in  1: synchronously clear all counters; does not affect lock.
- `locked`  out  1: checker is in LOCKED.
- `err_word`  out  1: one-cycle pulse when a locked word mismatches.
- `err_word_cnt`  out  32: errored words while locked; saturates at all-ones.
- `err_bit_cnt`  out  32: errored bits while locked, using the popcount of the XOR; saturates.
- `word_cnt`  out  32: words checked while locked; saturates.

## Operation
- Polynomial is x^7+x^6+1, so s[n] = s[n-6] ^ s[n-7] over the serial bit stream.
- Next-word prediction: extend the stream of 7 seed bits, `seed[0..6]` = bits `W-7..W-1` of the reference word, by `W` bits. The extension gives `exp[i]`.
- States are SEARCH and LOCKED. On reset the state is SEARCH, the good-word count is 0, and the error run is 0.
- SEARCH, on an `enable` cycle:
  - The reference is the previous valid received word.
  - A word that matches the prediction and is non-zero increments the good-word count.
  - A mismatching word or an all-zero word clears the good-word count.
  - The reference is always replaced by the received word.
  - When the good-word count reaches `LOCK_CNT`, the state moves to LOCKED.
- LOCKED, on an `enable` cycle:
  - The reference becomes the *expected* word, not the received one, so a single error cannot propagate.
  - `word_cnt` increments by 1.
  - On a mismatch, `err_word` pulses, `err_word_cnt` increments by 1, and `err_bit_cnt` increments by the popcount.
  - The error run counts consecutive mismatches and clears on any match.
  - When the error run reaches `UNLOCK_CNT`, the state moves to SEARCH with the good-word count at 0. The reference is reloaded from the received word.
- Cycles without `enable` change nothing: state, reference and counters hold.
- All counters saturate at `32'hFFFF_FFFF` and never wrap.
- `clear_cnt` zeroes the three counters. If a counter would increment in the same cycle, `clear_cnt` wins and the counter reads 0.

## Timing
- All outputs are registered. After reset: `locked`=0, `err_word`=0, and all counters are 0.
- `locked` rises in the cycle after the `enable` cycle that carries the `LOCK_CNT`-th consecutive good word.
- `locked` falls in the cycle after the `UNLOCK_CNT`-th consecutive errored word.
- `err_word` and the counter updates appear in the cycle after the offending `enable` cycle.
- In the word that causes loss of lock, that final word is still counted in all three counters.
- Asserting `rst_n`=0 mid-stream returns the block to reset values at the next edge, overriding `enable` and `clear_cnt`.
- Minimum lock time from reset is `LOCK_CNT`+1 valid words, because the first word only seeds the reference.

## Structure
- Package `phy_chk_pkg` holds:
  - the state enum `chk_state_e` {SEARCH, LOCKED};
  - the PRBS7 tap constants;
  - the function `prbs7_next_word(ref)` that returns the `W`-bit prediction.
- Sub-module `popcount_w` is a combinational bit count of the XOR mismatch vector, with output width $clog2(W)+1.
- The top level holds the FSM, reference register, run counters and saturating counters.

## Test plan
- Reset, then clean PRBS7 from seed 7'h7F with `enable` held high → `locked`=1 after exactly 5 words; `err_word_cnt`=0 and `err_bit_cnt`=0 after 100 words; `word_cnt`=96.
- Once locked, flip bits 0 and 17 of one word → one `err_word` pulse, `err_word_cnt`=1 and `err_bit_cnt`=2. The following words match, so there is no error propagation and lock is held.
- Once locked, drive 8 consecutive garbage words → `locked` falls the cycle after the 8th; `err_word_cnt`=8. Resume clean PRBS → relock after 5 words.
- Drive all-zero words continuously → `locked` stays 0 indefinitely.
- Insert `enable`=0 gaps of 1–3 cycles in a clean stream → lock and the counts are unaffected. Pulse `clear_cnt` in the same cycle as an error → all counters read 0.
- Preset `err_bit_cnt` near saturation by forcing or a long error run, then add errors → the counter holds at `32'hFFFF_FFFF` and does not wrap.
